drive_sequencer: RTL and testbench



---
 rtl/drive_sequencer.sv | 162 ++++++++++++++++
 tb/tb_drive_sequencer.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/drive_sequencer.sv
// Safety sequencer between the movement system and the PWM generator.
// It inserts coast dead-time on reversals, enforces overcurrent lockout and latches faults.
module drive_sequencer #(
  parameter int DEADTIME  = 1000,
  parameter int LOCKOUT   = 50000,
  parameter int MAX_RETRY = 3,
  parameter int CNT_W     = 16
) (
  input  logic       CLK,
  input  logic       RSTn,
  input  logic [1:0] ReqA,
  input  logic [1:0] ReqB,
  input  logic       OverA,
  input  logic       OverB,
  input  logic       OverBat,
  input  logic       ClearFault,
  output logic [1:0] DriveA,
  output logic [1:0] DriveB,
  output logic       Fault,
  output logic       Busy,
  output logic [1:0] RetryCount
);

  typedef enum logic [1:0] {
    ST_RUN,
    ST_DEAD,
    ST_LOCKOUT,
    ST_FAULT
  } state_t;

  localparam logic [CNT_W-1:0] DEAD_LAST = CNT_W'(DEADTIME - 1);
  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCKOUT - 1);
  localparam logic [2:0]       RETRY_MAX = 3'(MAX_RETRY);

  state_t           state;
  logic [CNT_W-1:0] timer;
  logic [CNT_W-1:0] timer_inc;
  logic [2:0]       ov_meta;
  logic [2:0]       ov_stable;
  logic             ov_sync;
  logic             reversal;
  logic             trip_now;
  logic             trip_faults;
  logic [1:0]       retry_inc;

  function automatic logic is_reversal(input logic [1:0] cur, input logic [1:0] req);
    return (cur == 2'b01 && req == 2'b10) || (cur == 2'b10 && req == 2'b01);
  endfunction

  // Each overcurrent flag is asynchronous, so every one gets its own two-flop synchroniser.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      ov_meta   <= '0;
      ov_stable <= '0;
    end else begin
      ov_meta   <= {OverBat, OverB, OverA};
      ov_stable <= ov_meta;
    end
  end

  assign ov_sync     = |ov_stable;
  assign reversal    = is_reversal(DriveA, ReqA) || is_reversal(DriveB, ReqB);
  assign timer_inc   = (timer == '1) ? timer : timer + 1'b1;
  assign trip_faults = ({1'b0, RetryCount} + 3'd1) >= RETRY_MAX;
  assign retry_inc   = RetryCount + 2'd1;

  always_comb begin
    trip_now = 1'b0;
    case (state)
      ST_RUN, ST_DEAD: trip_now = ov_sync;
      // A lockout only re-arms at its final cycle; overcurrent mid-lockout is absorbed.
      ST_LOCKOUT:      trip_now = ov_sync && (timer == LOCK_LAST);
      default:         trip_now = 1'b0;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state      <= ST_RUN;
      timer      <= '0;
      DriveA     <= 2'b00;
      DriveB     <= 2'b00;
      Fault      <= 1'b0;
      Busy       <= 1'b0;
      RetryCount <= 2'b00;
    end else if (trip_now) begin
      DriveA <= 2'b00;
      DriveB <= 2'b00;
      timer  <= '0;
      if (trip_faults) begin
        state      <= ST_FAULT;
        RetryCount <= RETRY_MAX[1:0];
        Fault      <= 1'b1;
        Busy       <= 1'b0;
      end else begin
        state      <= ST_LOCKOUT;
        RetryCount <= retry_inc;
        Busy       <= 1'b1;
      end
    end else begin
      case (state)
        ST_RUN: begin
          if (reversal) begin
            state  <= ST_DEAD;
            timer  <= '0;
            DriveA <= 2'b00;
            DriveB <= 2'b00;
            Busy   <= 1'b1;
          end else begin
            DriveA <= ReqA;
            DriveB <= ReqB;
            // Retry decay: a full LOCKOUT window of clean running forgives past trips.
            if (RetryCount != 2'b00) begin
              if (timer == LOCK_LAST) RetryCount <= 2'b00;
              else                    timer      <= timer_inc;
            end
          end
        end
        ST_DEAD: begin
          if (timer == DEAD_LAST) begin
            state  <= ST_RUN;
            timer  <= '0;
            DriveA <= ReqA;
            DriveB <= ReqB;
            Busy   <= 1'b0;
          end else begin
            timer <= timer_inc;
          end
        end
        ST_LOCKOUT: begin
          if (timer == LOCK_LAST) begin
            state  <= ST_RUN;
            timer  <= '0;
            DriveA <= ReqA;
            DriveB <= ReqB;
            Busy   <= 1'b0;
          end else begin
            timer <= timer_inc;
          end
        end
        ST_FAULT: begin
          if (ClearFault && !ov_sync) begin
            state      <= ST_RUN;
            timer      <= '0;
            RetryCount <= 2'b00;
            Fault      <= 1'b0;
            DriveA     <= ReqA;
            DriveB     <= ReqB;
          end
        end
        default: begin
          state  <= ST_RUN;
          timer  <= '0;
          DriveA <= 2'b00;
          DriveB <= 2'b00;
          Busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_drive_sequencer.sv
// Directed plus randomized bench for drive_sequencer, checked every cycle against
// a countdown-based behavioural model of the sequencing rules.
module tb_drive_sequencer;

  localparam int DT = 4;
  localparam int LK = 8;
  localparam int MR = 3;

  logic       CLK;
  logic       RSTn;
  logic [1:0] ReqA, ReqB;
  logic       OverA, OverB, OverBat, ClearFault;
  logic [1:0] DriveA, DriveB;
  logic       Fault, Busy;
  logic [1:0] RetryCount;

  int n_assert = 0;
  int n_fail   = 0;

  drive_sequencer #(
    .DEADTIME(DT), .LOCKOUT(LK), .MAX_RETRY(MR), .CNT_W(8)
  ) dut (
    .CLK(CLK), .RSTn(RSTn), .ReqA(ReqA), .ReqB(ReqB),
    .OverA(OverA), .OverB(OverB), .OverBat(OverBat), .ClearFault(ClearFault),
    .DriveA(DriveA), .DriveB(DriveB), .Fault(Fault), .Busy(Busy),
    .RetryCount(RetryCount)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Model: modes with countdowns rather than an up-counting timer.
  localparam int M_NORMAL  = 0;
  localparam int M_COAST   = 1;
  localparam int M_TRIP    = 2;
  localparam int M_LATCHED = 3;

  int         m_mode;
  int         m_left;
  int         m_decay;
  int         m_retry;
  logic [1:0] m_da, m_db;
  bit         ov_d1, ov_d2;

  function automatic bit flips(input logic [1:0] cur, input logic [1:0] nxt);
    return (cur inside {2'b01, 2'b10}) && (nxt inside {2'b01, 2'b10}) && (cur != nxt);
  endfunction

  task automatic model_reset();
    m_mode = M_NORMAL; m_left = 0; m_decay = LK; m_retry = 0;
    m_da = 2'b00; m_db = 2'b00; ov_d1 = 0; ov_d2 = 0;
  endtask

  task automatic model_resume();
    m_mode = M_NORMAL; m_da = ReqA; m_db = ReqB; m_decay = LK;
  endtask

  task automatic model_trip();
    m_da = 2'b00; m_db = 2'b00;
    if (m_retry + 1 >= MR) begin
      m_mode = M_LATCHED; m_retry = MR;
    end else begin
      m_retry = m_retry + 1; m_mode = M_TRIP; m_left = LK;
    end
  endtask

  task automatic model_edge();
    bit ov;
    if (!RSTn) begin
      model_reset();
      return;
    end
    ov = ov_d2;
    ov_d2 = ov_d1;
    ov_d1 = OverA | OverB | OverBat;
    case (m_mode)
      M_NORMAL: begin
        if (ov) model_trip();
        else if (flips(m_da, ReqA) || flips(m_db, ReqB)) begin
          m_mode = M_COAST; m_left = DT; m_da = 2'b00; m_db = 2'b00;
        end else begin
          m_da = ReqA; m_db = ReqB;
          if (m_retry != 0) begin
            m_decay = m_decay - 1;
            if (m_decay == 0) m_retry = 0;
          end
        end
      end
      M_COAST: begin
        if (ov) model_trip();
        else begin
          m_left = m_left - 1;
          if (m_left == 0) model_resume();
        end
      end
      M_TRIP: begin
        m_left = m_left - 1;
        if (m_left == 0) begin
          if (ov) model_trip();
          else    model_resume();
        end
      end
      default: begin
        if (ClearFault && !ov) begin
          m_retry = 0;
          model_resume();
        end
      end
    endcase
  endtask

  task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic compare_model(input string tag);
    chk({tag, ".DriveA"},     {2'b00, DriveA},     {2'b00, m_da});
    chk({tag, ".DriveB"},     {2'b00, DriveB},     {2'b00, m_db});
    chk({tag, ".Busy"},       {3'b000, Busy},      {3'b000, (m_mode == M_COAST || m_mode == M_TRIP)});
    chk({tag, ".Fault"},      {3'b000, Fault},     {3'b000, (m_mode == M_LATCHED)});
    chk({tag, ".RetryCount"}, {2'b00, RetryCount}, 4'(m_retry));
  endtask

  task automatic tick(input string tag);
    @(posedge CLK);
    model_edge();
    #1;
    compare_model(tag);
    $display("[%0t] %s req=%0d/%0d drive=%0d/%0d busy=%0d fault=%0d retry=%0d",
             $time, tag, ReqA, ReqB, DriveA, DriveB, Busy, Fault, RetryCount);
    @(negedge CLK);
  endtask

  task automatic ticks(input string tag, input int n);
    for (int i = 0; i < n; i++) tick(tag);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, ".DriveA"},     {2'b00, DriveA},     4'd0);
    chk({tag, ".DriveB"},     {2'b00, DriveB},     4'd0);
    chk({tag, ".Busy"},       {3'b000, Busy},      4'd0);
    chk({tag, ".Fault"},      {3'b000, Fault},     4'd0);
    chk({tag, ".RetryCount"}, {2'b00, RetryCount}, 4'd0);
  endtask

  // Assert reset between clock edges, check outputs clear immediately, then release.
  task automatic async_reset(input string tag);
    #2;
    RSTn = 1'b0;
    #1;
    check_all_zero(tag);
    OverA = 0; OverB = 0; OverBat = 0; ClearFault = 0;
    tick({tag, "_held"});
    RSTn = 1'b1;
  endtask

  int bat_hold;

  initial begin
    RSTn = 1'b1; ReqA = 0; ReqB = 0; OverA = 0; OverB = 0; OverBat = 0; ClearFault = 0;
    model_reset();
    #1 RSTn = 1'b0;
    #2 check_all_zero("reset");
    @(negedge CLK);
    tick("reset_hold");
    RSTn = 1'b1;

    // Pass-through with one-cycle latency.
    ReqA = 2'b01; ReqB = 2'b01;
    tick("pass");
    chk("pass.DriveA", {2'b00, DriveA}, 4'd1);
    chk("pass.Busy",   {3'b000, Busy},  4'd0);
    tick("pass");

    // Reversal on A: DT cycles of coast, then new direction.
    ReqA = 2'b10;
    ticks("dead", DT);
    chk("dead.Busy", {3'b000, Busy}, 4'd1);
    tick("dead_exit");
    chk("dead_exit.DriveA", {2'b00, DriveA}, 4'd2);
    tick("run");

    // Coast between directions is not a reversal.
    ReqA = 2'b00; tick("coast_mid");
    ReqA = 2'b01; tick("coast_fwd");
    chk("coast_fwd.Busy", {3'b000, Busy}, 4'd0);

    // Single-cycle overcurrent pulse on B.
    OverB = 1'b1; tick("overb");
    OverB = 1'b0; ticks("overb", 2);
    chk("overb.RetryCount", {2'b00, RetryCount}, 4'd1);
    ticks("lockout", LK + LK + 2);
    chk("decay.RetryCount", {2'b00, RetryCount}, 4'd0);

    // Sustained battery overcurrent walks the retry count up to a fault.
    OverBat = 1'b1;
    ticks("bat", 3 * LK + 6);
    chk("bat.Fault",      {3'b000, Fault},     4'd1);
    chk("bat.RetryCount", {2'b00, RetryCount}, 4'd3);

    // Clear is refused while overcurrent persists, accepted once it is gone.
    ClearFault = 1'b1; tick("clr_blocked");
    ClearFault = 1'b0; ticks("clr_blocked", 2);
    OverBat = 1'b0; ticks("bat_low", 3);
    ReqA = 2'b10; ReqB = 2'b11;
    ClearFault = 1'b1; tick("clr_ok");
    ClearFault = 1'b0; ticks("after_clr", 2);

    // Reset in the middle of a lockout.
    OverA = 1'b1; tick("ova");
    OverA = 1'b0; ticks("ova", 5);
    async_reset("rst_lock");
    tick("post_rst_lock");
    chk("post_rst_lock.RetryCount", {2'b00, RetryCount}, 4'd0);

    // Reset in the middle of a dead-time.
    ReqA = 2'b01; ReqB = 2'b00; ticks("pre_dead", 2);
    ReqA = 2'b10; ticks("mid_dead", 2);
    async_reset("rst_dead");
    ticks("post_rst_dead", 2);

    // Randomized traffic.
    bat_hold = 0;
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(3) == 0) ReqA = 2'($urandom_range(3));
      if ($urandom_range(3) == 0) ReqB = 2'($urandom_range(3));
      OverA = ($urandom_range(59) == 0);
      OverB = ($urandom_range(59) == 0);
      if (bat_hold > 0) bat_hold--;
      else if ($urandom_range(149) == 0) bat_hold = $urandom_range(30, 5);
      OverBat = (bat_hold > 0);
      ClearFault = ($urandom_range(7) == 0);
      tick("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
